// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch resolution/prediction unit.
//   - funct3 encodings of the six RV32I conditional branches
//   - sat_update(): saturating up/down step of a prediction counter
//   - ctr_reset():  weakly-not-taken reset value for a counter width
// Counter helpers work on a 32-bit container plus an explicit width so the
// package stays non-parametric; callers cast the result to their width.
package branch_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // All-ones value of a counter that is 'bits' wide.
    function automatic logic [31:0] ctr_max(input int bits);
        return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    endfunction

    // One step towards taken/not-taken, clamped at all-ones and zero.
    function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int          bits);
        logic [31:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ctr_max(bits)) nxt = ctr + 32'd1;
        end else begin
            if (ctr != 32'd0) nxt = ctr - 32'd1;
        end
        return nxt;
    endfunction

    // 0b01..1: MSB clear, all lower bits set (0 for a 1-bit counter).
    function automatic logic [31:0] ctr_reset(input int bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// branch_compare: combinational RV32I branch condition evaluator.
// Ports:
//   funct3  - branch condition field
//   a, b    - RS1/RS2 operand values (XLEN wide)
//   taken   - condition holds (0 for illegal encodings)
//   legal   - funct3 is one of the six conditional branch encodings
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken,
    output logic            legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LT:   taken = ($signed(a) <  $signed(b));
            BR_GE:   taken = ($signed(a) >= $signed(b));
            BR_LTU:  taken = (a <  b);
            BR_GEU:  taken = (a >= b);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves EX-stage conditional branches, predicts
// IF-stage branches from a PC-indexed table of saturating counters, and
// raises the mispredict flush with the corrected next PC.
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   FetchPC/PredTaken - IF lookup address and combinational prediction
//   ExValid, Stall, Branch, funct3, RS1Data, RS2Data, ExPC, ExTarget,
//   ExPredTaken       - EX-stage instruction and its carried prediction
//   BranchTaken, Mispredict, RedirectPC - combinational resolution outputs
//   BranchCount, MispredictCount        - registered saturating statistics
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] FetchPC,
    output logic            PredTaken,
    input  logic            ExValid,
    input  logic            Stall,
    input  logic            Branch,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] RS1Data,
    input  logic [XLEN-1:0] RS2Data,
    input  logic [XLEN-1:0] ExPC,
    input  logic [XLEN-1:0] ExTarget,
    input  logic            ExPredTaken,
    output logic            BranchTaken,
    output logic            Mispredict,
    output logic [XLEN-1:0] RedirectPC,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredictCount
);

    localparam int                  IDX_W   = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset(CTR_BITS));

    logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

    logic [IDX_W-1:0]    fetch_idx;
    logic [IDX_W-1:0]    ex_idx;
    logic                cmp_taken;
    logic                cmp_legal;
    logic                qual;
    logic                resolve;
    logic [CTR_BITS-1:0] ctr_next;
    logic                unused_pc_bits;

    assign fetch_idx = FetchPC[IDX_W+1:2];
    assign ex_idx    = ExPC[IDX_W+1:2];
    assign unused_pc_bits = ^{FetchPC[XLEN-1:IDX_W+2], FetchPC[1:0],
                              ExPC[XLEN-1:IDX_W+2], ExPC[1:0]};

    // Plain read of the registered table: no bypass of a same-cycle update.
    assign PredTaken = bht[fetch_idx][CTR_BITS-1];

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .funct3 (funct3),
        .a      (RS1Data),
        .b      (RS2Data),
        .taken  (cmp_taken),
        .legal  (cmp_legal)
    );

    // Outputs resolve even under Stall; only state updates are held off.
    assign qual        = ExValid & Branch & cmp_legal;
    assign resolve     = qual & ~Stall;
    assign BranchTaken = qual & cmp_taken;
    assign Mispredict  = qual & (cmp_taken != ExPredTaken);
    assign RedirectPC  = BranchTaken ? ExTarget : (ExPC + XLEN'(4));

    assign ctr_next = CTR_BITS'(sat_update(32'(bht[ex_idx]), cmp_taken, CTR_BITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RST;
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else if (resolve) begin
            bht[ex_idx] <= ctr_next;
            if (BranchCount != 32'hFFFF_FFFF)
                BranchCount <= BranchCount + 32'd1;
            if (Mispredict && (MispredictCount != 32'hFFFF_FFFF))
                MispredictCount <= MispredictCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed steps from the test
// plan followed by randomized traffic, all compared against a behavioural
// model (integer counters per table slot, arithmetic branch conditions).
module tb_branch_predict_unit;

    localparam int ENTRIES = 64;
    localparam int CMAX    = 3;   // 2-bit counter ceiling
    localparam int CWEAK   = 1;   // weakly-not-taken
    localparam int CTHR    = 2;   // predict taken at or above this

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] FetchPC;
    logic        PredTaken;
    logic        ExValid, Stall, Branch, ExPredTaken;
    logic [2:0]  funct3;
    logic [31:0] RS1Data, RS2Data, ExPC, ExTarget;
    logic        BranchTaken, Mispredict;
    logic [31:0] RedirectPC, BranchCount, MispredictCount;

    always #5 clk = ~clk;

    branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(ENTRIES), .CTR_BITS(2)) dut (
        .clk(clk), .reset(reset), .FetchPC(FetchPC), .PredTaken(PredTaken),
        .ExValid(ExValid), .Stall(Stall), .Branch(Branch), .funct3(funct3),
        .RS1Data(RS1Data), .RS2Data(RS2Data), .ExPC(ExPC), .ExTarget(ExTarget),
        .ExPredTaken(ExPredTaken), .BranchTaken(BranchTaken),
        .Mispredict(Mispredict), .RedirectPC(RedirectPC),
        .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    int checks   = 0;
    int failures = 0;

    int          m_ctr [ENTRIES];
    int unsigned m_bc, m_mc;

    // Values seen just before the most recent clock edge.
    logic obs_pred, obs_taken, obs_mis;
    logic [31:0] obs_redir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic longint as_signed(input logic [31:0] v);
        return v[31] ? (longint'(v) - 64'sh1_0000_0000) : longint'(v);
    endfunction

    function automatic bit ref_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return as_signed(a) <  as_signed(b);
            3'd5: return as_signed(a) >= as_signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CWEAK;
        m_bc = 0;
        m_mc = 0;
    endtask

    // Drive one cycle, check the combinational outputs against the model,
    // clock it, advance the model, then check the statistics counters.
    task automatic do_cycle(input logic rst, input logic v, input logic br, input logic st,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expc, input logic [31:0] tgt, input logic ept,
                            input logic [31:0] fpc);
        bit legal, q, tk, mis;
        logic [31:0] redir;
        reset = rst; ExValid = v; Branch = br; Stall = st; funct3 = f3;
        RS1Data = a; RS2Data = b; ExPC = expc; ExTarget = tgt; ExPredTaken = ept;
        FetchPC = fpc;
        #1;
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        q     = v && br && legal;
        tk    = q && ref_cond(f3, a, b);
        mis   = q && (tk != ept);
        redir = tk ? tgt : expc + 32'd4;
        check("BranchTaken", {31'd0, BranchTaken}, {31'd0, tk});
        check("Mispredict",  {31'd0, Mispredict},  {31'd0, mis});
        check("RedirectPC",  RedirectPC, redir);
        check("PredTaken",   {31'd0, PredTaken},   {31'd0, m_ctr[slot(fpc)] >= CTHR});
        obs_pred = PredTaken; obs_taken = BranchTaken; obs_mis = Mispredict;
        obs_redir = RedirectPC;
        @(posedge clk);
        if (rst) model_reset();
        else if (q && !st) begin
            if (tk) m_ctr[slot(expc)] = (m_ctr[slot(expc)] < CMAX) ? m_ctr[slot(expc)] + 1 : CMAX;
            else    m_ctr[slot(expc)] = (m_ctr[slot(expc)] > 0) ? m_ctr[slot(expc)] - 1 : 0;
            m_bc++;
            if (mis) m_mc++;
        end
        #1;
        check("BranchCount",     BranchCount,     m_bc);
        check("MispredictCount", MispredictCount, m_mc);
    endtask

    task automatic idle(input logic [31:0] fpc);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, fpc);
    endtask

    int unsigned bc0, mc0;
    logic [31:0] ra, rb, rpc, rfpc;
    logic [2:0]  rf;

    initial begin
        reset = 1'b1; ExValid = 1'b0; Branch = 1'b0; Stall = 1'b0; funct3 = 3'd0;
        RS1Data = '0; RS2Data = '0; ExPC = '0; ExTarget = '0; ExPredTaken = 1'b0;
        FetchPC = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 32'd0);

        // Every table slot reads not-taken after reset; counters clear.
        reset = 1'b0;
        for (int pc = 0; pc <= 32'h3FC; pc += 4) begin
            FetchPC = pc;
            #1;
            check("reset_pred", {31'd0, PredTaken}, 32'd0);
        end
        check("reset_bc", BranchCount, 32'd0);
        check("reset_mc", MispredictCount, 32'd0);

        // Condition checks held under Stall so the table is untouched.
        do_cycle(0, 1, 1, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h800, 1'b0, 32'h0);
        check("blt_neg1_lt_1", {31'd0, obs_taken}, 32'd1);
        do_cycle(0, 1, 1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h800, 1'b0, 32'h0);
        check("bltu_not_taken", {31'd0, obs_taken}, 32'd0);
        do_cycle(0, 1, 1, 1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h800, 1'b0, 32'h0);
        check("bgeu_taken", {31'd0, obs_taken}, 32'd1);
        do_cycle(0, 1, 1, 1, 3'b000, 32'd5, 32'd5, 32'h0, 32'h800, 1'b0, 32'h0);
        check("beq_taken", {31'd0, obs_taken}, 32'd1);
        check("beq_redirect", obs_redir, 32'h800);
        check("stall_no_count", BranchCount, 32'd0);

        // Training 0x40 towards taken; prediction follows one cycle later.
        do_cycle(0, 1, 1, 0, 3'b000, 32'd7, 32'd7, 32'h40, 32'h80, 1'b0, 32'h40);
        check("train_pred_c1", {31'd0, obs_pred}, 32'd0);
        do_cycle(0, 1, 1, 0, 3'b000, 32'd7, 32'd7, 32'h40, 32'h80, 1'b0, 32'h40);
        check("train_pred_c2", {31'd0, obs_pred}, 32'd1);
        do_cycle(0, 1, 1, 0, 3'b000, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1, 32'h40);
        check("train_pred_c3", {31'd0, obs_pred}, 32'd1);
        do_cycle(0, 1, 1, 0, 3'b000, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1, 32'h40);
        // Saturated at 3: two not-taken steps are needed to drop below taken.
        do_cycle(0, 1, 1, 0, 3'b001, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1, 32'h40);
        check("sat_pred_after4", {31'd0, obs_pred}, 32'd1);
        do_cycle(0, 1, 1, 0, 3'b001, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1, 32'h40);
        check("sat_pred_after_nt1", {31'd0, obs_pred}, 32'd1);
        idle(32'h40);
        check("sat_pred_after_nt2", {31'd0, obs_pred}, 32'd0);

        // Predicted taken, actually not taken.
        bc0 = m_bc; mc0 = m_mc;
        do_cycle(0, 1, 1, 0, 3'b000, 32'd1, 32'd2, 32'h100, 32'h200, 1'b1, 32'h0);
        check("mis_flag", {31'd0, obs_mis}, 32'd1);
        check("mis_redirect", obs_redir, 32'h104);
        check("mis_bc_inc", BranchCount, bc0 + 1);
        check("mis_mc_inc", MispredictCount, mc0 + 1);

        // Same event stalled three cycles then released: counted once.
        bc0 = m_bc; mc0 = m_mc;
        repeat (3) begin
            do_cycle(0, 1, 1, 1, 3'b000, 32'd1, 32'd2, 32'h100, 32'h200, 1'b1, 32'h0);
            check("stall_mis_held", {31'd0, obs_mis}, 32'd1);
            check("stall_bc_hold", BranchCount, bc0);
        end
        do_cycle(0, 1, 1, 0, 3'b000, 32'd1, 32'd2, 32'h100, 32'h200, 1'b1, 32'h0);
        check("stall_bc_once", BranchCount, bc0 + 1);
        check("stall_mc_once", MispredictCount, mc0 + 1);

        // Illegal funct3: no outcome, no flush, no counting.
        bc0 = m_bc; mc0 = m_mc;
        do_cycle(0, 1, 1, 0, 3'b010, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1, 32'h40);
        check("illegal_taken", {31'd0, obs_taken}, 32'd0);
        check("illegal_mis", {31'd0, obs_mis}, 32'd0);
        check("illegal_bc", BranchCount, bc0);
        check("illegal_mc", MispredictCount, mc0);

        // Randomized traffic over a few colliding PCs.
        for (int n = 0; n < 400; n++) begin
            rf   = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? ra : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)));
            rpc  = 32'($urandom_range(0, 15)) << 2;
            rfpc = ($urandom_range(0, 1) == 0) ? rpc : (32'($urandom_range(0, 15)) << 2);
            do_cycle(1'b0, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
                     1'($urandom_range(0, 3) == 0), rf, ra, rb, rpc, $urandom,
                     1'($urandom_range(0, 1)), rfpc);
        end

        // Reset wins over a same-cycle resolve event.
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'd9, 32'd9, 32'h40, 32'h80, 1'b0, 32'h40);
        check("rst_dom_bc", BranchCount, 32'd0);
        check("rst_dom_mc", MispredictCount, 32'd0);
        idle(32'h40);
        check("rst_dom_pred", {31'd0, obs_pred}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
